// File: rtl/axis_entry_packer.sv
// axis_entry_packer
// AXI-Stream ingress adapter for the resizer buffer. Each accepted beat has its
// kept lanes compacted toward lane 0, is encoded into the per-lane
// {last, keep, data} entry format and is queued in a two-entry holding FIFO.
// The FIFO head is offered to the buffer and is held while the buffer reports
// overflow. Beat and packet statistics are counted on the buffer side.
module axis_entry_packer #(
    parameter int S_KEEP_WIDTH    = 3,
    parameter int T_DATA_WIDTH    = 1,
    parameter int BUF_IN_ENTRY_SZ = (2 + T_DATA_WIDTH) * S_KEEP_WIDTH,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic [S_KEEP_WIDTH*T_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0]                s_axis_tkeep,
    input  logic                                   s_axis_tlast,
    output logic                                   slave_entry_valid,
    output logic [BUF_IN_ENTRY_SZ-1:0]             slave_entry,
    input  logic                                   overflow,
    output logic                                   pkt_open,
    output logic [CNT_WIDTH-1:0]                   pkt_count,
    output logic [CNT_WIDTH-1:0]                   beat_count
);

    localparam int L = T_DATA_WIDTH + 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [BUF_IN_ENTRY_SZ-1:0]  slot0_q, slot0_d;
    logic [BUF_IN_ENTRY_SZ-1:0]  slot1_q, slot1_d;
    logic [CNT_WIDTH-1:0]        pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0]        beat_count_q, beat_count_d;

    logic                        accept;
    logic                        discard;
    logic                        push;
    logic                        pop;
    logic [BUF_IN_ENTRY_SZ-1:0]  packed_entry;

    // Saturating increment shared by both statistics counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // True when any lane of an entry carries the last flag.
    function automatic logic entry_has_last(input logic [BUF_IN_ENTRY_SZ-1:0] e);
        logic r;
        r = 1'b0;
        for (int j = 0; j < S_KEEP_WIDTH; j++) begin
            r = r | e[j*L + T_DATA_WIDTH + 1];
        end
        return r;
    endfunction

    // tready depends only on registers (plus reset) so overflow never reaches it combinationally.
    assign s_axis_tready     = !rst && (cnt_q != 2'd2);
    assign slave_entry_valid = (cnt_q != 2'd0);
    // Data slots are not reset; gating with valid keeps the output at zero while empty.
    assign slave_entry       = slave_entry_valid ? slot0_q : '0;
    assign pkt_open          = (state_q == ST_BODY);
    assign pkt_count         = pkt_count_q;
    assign beat_count        = beat_count_q;

    assign accept  = s_axis_tvalid && s_axis_tready;
    assign discard = (s_axis_tkeep == '0) && !s_axis_tlast;
    assign push    = accept && !discard;
    assign pop     = slave_entry_valid && !overflow;

    // Compact kept lanes to the bottom and encode them; last goes on the top kept lane.
    always_comb begin
        int rank;
        packed_entry = '0;
        rank         = 0;
        for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            if (s_axis_tkeep[i]) begin
                for (int j = 0; j < S_KEEP_WIDTH; j++) begin
                    if (rank == j) begin
                        packed_entry[j*L +: T_DATA_WIDTH] = s_axis_tdata[i*T_DATA_WIDTH +: T_DATA_WIDTH];
                        packed_entry[j*L + T_DATA_WIDTH]  = 1'b1;
                    end
                end
                rank = rank + 1;
            end
        end
        // A null tlast beat still needs a marker, so it lands in lane 0 with keep=0.
        if (s_axis_tlast) begin
            for (int j = 0; j < S_KEEP_WIDTH; j++) begin
                if ((rank == 0 && j == 0) || (rank == j + 1)) begin
                    packed_entry[j*L + T_DATA_WIDTH + 1] = 1'b1;
                end
            end
        end
    end

    // Holding FIFO next state: slot0 is the head, slot1 the second entry.
    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
        if (pop) begin
            // With one entry, a simultaneous push becomes the new head directly.
            if (push && (cnt_q == 2'd1)) begin
                slot0_d = packed_entry;
            end else begin
                slot0_d = slot1_q;
            end
            if (push && (cnt_q == 2'd2)) begin
                slot1_d = packed_entry;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                slot0_d = packed_entry;
            end else begin
                slot1_d = packed_entry;
            end
        end
    end

    // Packet framing state follows every accepted beat, including discarded null beats.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = s_axis_tlast ? ST_IDLE : ST_BODY;
        end
    end

    // Statistics advance on each buffer write.
    always_comb begin
        pkt_count_d  = pkt_count_q;
        beat_count_d = beat_count_q;
        if (pop) begin
            beat_count_d = sat_inc(beat_count_q);
            if (entry_has_last(slot0_q)) begin
                pkt_count_d = sat_inc(pkt_count_q);
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            pkt_count_q  <= '0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pkt_count_q  <= pkt_count_d;
            beat_count_q <= beat_count_d;
        end
    end

    // FIFO data slots; validity is tracked by cnt_q so they need no reset.
    always_ff @(posedge clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

endmodule

// File: tb/tb_axis_entry_packer.sv
// Scoreboard bench for axis_entry_packer with 3 lanes of 8 bits and 4-bit counters.
module tb_axis_entry_packer;

    localparam int SK = 3;
    localparam int TD = 8;
    localparam int CW = 4;
    localparam int EW = (2 + TD) * SK;

    logic           clk;
    logic           rst;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [SK*TD-1:0] s_axis_tdata;
    logic [SK-1:0]  s_axis_tkeep;
    logic           s_axis_tlast;
    logic           slave_entry_valid;
    logic [EW-1:0]  slave_entry;
    logic           overflow;
    logic           pkt_open;
    logic [CW-1:0]  pkt_count;
    logic [CW-1:0]  beat_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    axis_entry_packer #(
        .S_KEEP_WIDTH (SK),
        .T_DATA_WIDTH (TD),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tlast      (s_axis_tlast),
        .slave_entry_valid (slave_entry_valid),
        .slave_entry       (slave_entry),
        .overflow          (overflow),
        .pkt_open          (pkt_open),
        .pkt_count         (pkt_count),
        .beat_count        (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: an entry presented with overflow low at the negedge is written at the next posedge.
    always @(negedge clk) begin
        if (!rst && slave_entry_valid && !overflow) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL entry_unexpected: actual 0x%0h required none", slave_entry);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if (slave_entry !== e) begin
                    n_bad++;
                    $display("FAIL entry: actual 0x%0h required 0x%0h", slave_entry, e);
                end
            end
        end
    end

    // Present one beat until accepted; queue the hand-computed entry it must produce.
    task automatic send(input logic [23:0] d, input logic [2:0] k, input logic l,
                        input logic [EW-1:0] exp, input bit produce);
        int  waited;
        bit  ok;
        waited = 0;
        ok     = 1'b0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!ok && waited < 64) begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk);
                ok = 1'b1;
                if (produce) exp_q.push_back(exp);
            end
            waited++;
        end
        #1;
        s_axis_tvalid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: actual not accepted required accepted");
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !slave_entry_valid) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: actual %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        overflow      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_valid", {31'd0, slave_entry_valid}, 32'd0);
        check("rst_entry", {2'd0, slave_entry}, 32'd0);
        check("rst_pkt_open", {31'd0, pkt_open}, 32'd0);
        check("rst_pkt_count", {28'd0, pkt_count}, 32'd0);
        check("rst_beat_count", {28'd0, beat_count}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_release", {31'd0, s_axis_tready}, 32'd1);

        // Compaction: lanes 0 and 2 kept, last on the upper compacted lane
        send(24'hCCBBAA, 3'b101, 1'b1, {10'h000, 10'h3CC, 10'h1AA}, 1'b1);
        wait_drain();
        check("cmp_pkt_count", {28'd0, pkt_count}, 32'd1);
        check("cmp_beat_count", {28'd0, beat_count}, 32'd1);

        // Null beats
        send(24'h123456, 3'b000, 1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("null_no_entry", {31'd0, slave_entry_valid}, 32'd0);
        check("null_beat_count", {28'd0, beat_count}, 32'd1);
        check("null_pkt_count", {28'd0, pkt_count}, 32'd1);
        send(24'h000000, 3'b000, 1'b1, {10'h000, 10'h000, 10'h200}, 1'b1);
        wait_drain();
        check("nulllast_pkt_count", {28'd0, pkt_count}, 32'd2);
        check("nulllast_beat_count", {28'd0, beat_count}, 32'd2);

        // Packet state over a three-beat packet, with further compaction patterns
        send(24'h332211, 3'b110, 1'b0, {10'h000, 10'h133, 10'h122}, 1'b1);
        check("open_after_b0", {31'd0, pkt_open}, 32'd1);
        send(24'h000077, 3'b001, 1'b0, {10'h000, 10'h000, 10'h177}, 1'b1);
        check("open_after_b1", {31'd0, pkt_open}, 32'd1);
        send(24'h665544, 3'b111, 1'b1, {10'h366, 10'h155, 10'h144}, 1'b1);
        check("open_after_b2", {31'd0, pkt_open}, 32'd0);
        send(24'h00BB00, 3'b010, 1'b1, {10'h000, 10'h000, 10'h3BB}, 1'b1);
        wait_drain();
        check("seq_pkt_count", {28'd0, pkt_count}, 32'd4);
        check("seq_beat_count", {28'd0, beat_count}, 32'd6);

        // Back-pressure: FIFO fills, head holds, third beat waits
        overflow = 1'b1;
        send(24'h000011, 3'b001, 1'b1, {10'h000, 10'h000, 10'h311}, 1'b1);
        check("bp_tready_cnt1", {31'd0, s_axis_tready}, 32'd1);
        send(24'h220000, 3'b100, 1'b1, {10'h000, 10'h000, 10'h322}, 1'b1);
        check("bp_tready_cnt2", {31'd0, s_axis_tready}, 32'd0);
        fork
            send(24'h003300, 3'b011, 1'b1, {10'h000, 10'h333, 10'h100}, 1'b1);
        join_none
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            check("bp_head_hold", {2'd0, slave_entry}, {2'd0, 10'h000, 10'h000, 10'h311});
            check("bp_tready_low", {31'd0, s_axis_tready}, 32'd0);
        end
        overflow = 1'b0;
        wait fork;
        wait_drain();
        check("bp_beat_count", {28'd0, beat_count}, 32'd9);
        check("bp_pkt_count", {28'd0, pkt_count}, 32'd7);

        // Reset mid-packet with the FIFO full
        overflow = 1'b1;
        send(24'h000044, 3'b001, 1'b0, {10'h000, 10'h000, 10'h144}, 1'b1);
        send(24'h000055, 3'b001, 1'b0, {10'h000, 10'h000, 10'h155}, 1'b1);
        check("mid_pkt_open", {31'd0, pkt_open}, 32'd1);
        check("mid_full_tready", {31'd0, s_axis_tready}, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check("async_tready", {31'd0, s_axis_tready}, 32'd0);
        check("async_valid", {31'd0, slave_entry_valid}, 32'd0);
        check("async_entry", {2'd0, slave_entry}, 32'd0);
        check("async_pkt_open", {31'd0, pkt_open}, 32'd0);
        check("async_pkt_count", {28'd0, pkt_count}, 32'd0);
        check("async_beat_count", {28'd0, beat_count}, 32'd0);
        exp_q.delete();
        overflow = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_tready_release", {31'd0, s_axis_tready}, 32'd1);

        // Simultaneous push/pop at one entry, back-to-back beats
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'(i + 8'h10);
            send({16'h0000, b}, 3'b001, 1'b0, {10'h000, 10'h000, 2'b01, b}, 1'b1);
            check("stream_tready", {31'd0, s_axis_tready}, 32'd1);
            check("stream_valid", {31'd0, slave_entry_valid}, 32'd1);
        end
        check("stream_pkt_open", {31'd0, pkt_open}, 32'd1);
        wait_drain();
        check("stream_beat_count", {28'd0, beat_count}, 32'd8);
        check("stream_pkt_count", {28'd0, pkt_count}, 32'd0);

        // Counter saturation with 17 single-beat packets
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(i + 8'h40);
            send({16'h0000, b}, 3'b001, 1'b1, {10'h000, 10'h000, 2'b11, b}, 1'b1);
        end
        wait_drain();
        check("sat_pkt_count", {28'd0, pkt_count}, 32'd15);
        check("sat_beat_count", {28'd0, beat_count}, 32'd15);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
